// File: rtl/punc_control_pkg.sv
// Shared encodings for the PUnC LC3 controller: states, opcodes and every
// datapath mux-select value, so controller and datapath agree on one table.
package Defines;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] PC_SEL_PC_8_0  = 2'd0;
  localparam logic [1:0] PC_SEL_PC_10_0 = 2'd1;
  localparam logic [1:0] PC_SEL_RF_R1   = 2'd2;

  localparam logic [1:0] MEM_R_PC        = 2'd0;
  localparam logic [1:0] MEM_R_PC_8_0    = 2'd1;
  localparam logic [1:0] MEM_R_RF_R0     = 2'd2;
  localparam logic [1:0] MEM_R_RF_R1_5_0 = 2'd3;

  localparam logic [1:0] MEM_W_PC_8_0    = 2'd0;
  localparam logic [1:0] MEM_W_PREV      = 2'd1;
  localparam logic [1:0] MEM_W_RF_R1_5_0 = 2'd2;

  localparam logic [1:0] RF_W_DATA_ALU    = 2'd0;
  localparam logic [1:0] RF_W_DATA_PC_8_0 = 2'd1;
  localparam logic [1:0] RF_W_DATA_MEM    = 2'd2;
  localparam logic [1:0] RF_W_DATA_PC     = 2'd3;

  localparam logic RF_W_ADDR_R7   = 1'b0;
  localparam logic RF_W_ADDR_11_9 = 1'b1;

  localparam logic R0_ADDR_11_9 = 1'b0;
  localparam logic R0_ADDR_2_0  = 1'b1;

  localparam logic [1:0] ALU_PASSA = 2'd0;
  localparam logic [1:0] ALU_ADD   = 2'd1;
  localparam logic [1:0] ALU_AND   = 2'd2;
  localparam logic [1:0] ALU_NOT_B = 2'd3;

  localparam logic FIRST_VAL_IMM5 = 1'b0;
  localparam logic FIRST_VAL_R0   = 1'b1;

endpackage

// File: rtl/punc_control.sv
// PUnC LC3 control unit: FETCH/DECODE/EXEC(/EXEC2) sequencer driving all datapath strobes.
// Optional retired-instruction counter output enabled by defining PUNC_CTRL_PERF_EN.
module punc_control
  import Defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        nzp_true,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic [1:0]  pc_sel,
  output logic        ir_ld,
  output logic        ir_clr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  mem_r_addr_sel,
  output logic [1:0]  mem_w_addr_sel,
  output logic [1:0]  rf_w_data_sel,
  output logic        rf_w_addr_sel,
  output logic        rf_w_wr,
  output logic        rf_r0_addr_sel,
  output logic        rf_r0_rd,
  output logic        rf_r1_rd,
  output logic        prev_ld,
  output logic        nzp_ld,
  output logic        nzp_clr,
  output logic [1:0]  alu_sel,
  output logic        alu_first_val_sel,
`ifdef PUNC_CTRL_PERF_EN
  output logic [15:0] retired_count,
`endif
  output logic        halted
);

  state_t     state_q, state_d;
  logic [3:0] opcode;

  assign opcode = ir[15:12];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC:   state_d = (opcode == OP_LDI || opcode == OP_STI) ? S_EXEC2 : S_FETCH;
      S_EXEC2:  state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

`ifdef PUNC_CTRL_PERF_EN
  logic [15:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if ((state_q == S_EXEC && state_d == S_FETCH) || state_q == S_EXEC2)
      retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) retired_q <= '0;
    else     retired_q <= retired_d;
  end

  assign retired_count = retired_q;
`endif

  always_comb begin
    pc_ld = 1'b0; pc_clr = 1'b0; pc_inc = 1'b0; pc_sel = PC_SEL_PC_8_0;
    ir_ld = 1'b0; ir_clr = 1'b0;
    mem_rd = 1'b0; mem_wr = 1'b0;
    mem_r_addr_sel = MEM_R_PC; mem_w_addr_sel = MEM_W_PC_8_0;
    rf_w_data_sel = RF_W_DATA_ALU; rf_w_addr_sel = RF_W_ADDR_R7; rf_w_wr = 1'b0;
    rf_r0_addr_sel = R0_ADDR_11_9; rf_r0_rd = 1'b0; rf_r1_rd = 1'b0;
    prev_ld = 1'b0; nzp_ld = 1'b0; nzp_clr = 1'b0;
    alu_sel = ALU_PASSA; alu_first_val_sel = FIRST_VAL_IMM5;
    halted = 1'b0;

    // Reset overrides the state so an instruction caught mid-EXEC never commits.
    if (rst || state_q == S_INIT) begin
      pc_clr = 1'b1; ir_clr = 1'b1; nzp_clr = 1'b1;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_rd = 1'b1; mem_r_addr_sel = MEM_R_PC; ir_ld = 1'b1; pc_inc = 1'b1;
        end
        S_EXEC: begin
          case (opcode)
            OP_ADD, OP_AND: begin
              alu_sel  = (opcode == OP_ADD) ? ALU_ADD : ALU_AND;
              rf_r1_rd = 1'b1;
              if (ir[5]) begin
                alu_first_val_sel = FIRST_VAL_IMM5;
              end else begin
                alu_first_val_sel = FIRST_VAL_R0;
                rf_r0_addr_sel    = R0_ADDR_2_0;
                rf_r0_rd          = 1'b1;
              end
              rf_w_data_sel = RF_W_DATA_ALU; rf_w_addr_sel = RF_W_ADDR_11_9;
              rf_w_wr = 1'b1; nzp_ld = 1'b1;
            end
            OP_NOT: begin
              alu_sel = ALU_NOT_B; rf_r1_rd = 1'b1;
              rf_w_data_sel = RF_W_DATA_ALU; rf_w_addr_sel = RF_W_ADDR_11_9;
              rf_w_wr = 1'b1; nzp_ld = 1'b1;
            end
            OP_BR: begin
              if (nzp_true) begin
                pc_ld = 1'b1; pc_sel = PC_SEL_PC_8_0;
              end
            end
            OP_JMP: begin
              rf_r1_rd = 1'b1; pc_sel = PC_SEL_RF_R1; pc_ld = 1'b1;
            end
            OP_JSR: begin
              // R7 captures the current PC on this edge while the PC loads the target.
              rf_w_data_sel = RF_W_DATA_PC; rf_w_addr_sel = RF_W_ADDR_R7;
              rf_w_wr = 1'b1; pc_ld = 1'b1;
              if (ir[11]) begin
                pc_sel = PC_SEL_PC_10_0;
              end else begin
                pc_sel = PC_SEL_RF_R1; rf_r1_rd = 1'b1;
              end
            end
            OP_LD, OP_LDR: begin
              mem_rd = 1'b1;
              if (opcode == OP_LD) begin
                mem_r_addr_sel = MEM_R_PC_8_0;
              end else begin
                mem_r_addr_sel = MEM_R_RF_R1_5_0; rf_r1_rd = 1'b1;
              end
              rf_w_data_sel = RF_W_DATA_MEM; rf_w_addr_sel = RF_W_ADDR_11_9;
              rf_w_wr = 1'b1; nzp_ld = 1'b1;
            end
            OP_LEA: begin
              rf_w_data_sel = RF_W_DATA_PC_8_0; rf_w_addr_sel = RF_W_ADDR_11_9;
              rf_w_wr = 1'b1; nzp_ld = 1'b1;
            end
            OP_ST, OP_STR: begin
              mem_wr = 1'b1;
              if (opcode == OP_ST) begin
                mem_w_addr_sel = MEM_W_PC_8_0;
              end else begin
                mem_w_addr_sel = MEM_W_RF_R1_5_0; rf_r1_rd = 1'b1;
              end
              rf_r0_addr_sel = R0_ADDR_11_9; rf_r0_rd = 1'b1;
            end
            OP_LDI: begin
              // First LDI step parks the pointer in DR; EXEC2 reads through it.
              mem_rd = 1'b1; mem_r_addr_sel = MEM_R_PC_8_0;
              rf_w_data_sel = RF_W_DATA_MEM; rf_w_addr_sel = RF_W_ADDR_11_9;
              rf_w_wr = 1'b1;
            end
            OP_STI: begin
              mem_rd = 1'b1; mem_r_addr_sel = MEM_R_PC_8_0; prev_ld = 1'b1;
            end
            default: ;
          endcase
        end
        S_EXEC2: begin
          if (opcode == OP_LDI) begin
            rf_r0_addr_sel = R0_ADDR_11_9; rf_r0_rd = 1'b1;
            mem_rd = 1'b1; mem_r_addr_sel = MEM_R_RF_R0;
            rf_w_data_sel = RF_W_DATA_MEM; rf_w_addr_sel = RF_W_ADDR_11_9;
            rf_w_wr = 1'b1; nzp_ld = 1'b1;
          end else if (opcode == OP_STI) begin
            mem_wr = 1'b1; mem_w_addr_sel = MEM_W_PREV;
            rf_r0_addr_sel = R0_ADDR_11_9; rf_r0_rd = 1'b1;
          end
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_punc_control.sv
// Directed bench for punc_control; retired_count is checked when PUNC_CTRL_PERF_EN is defined.
module tb_punc_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        nzp_true;
  logic        pc_ld, pc_clr, pc_inc;
  logic [1:0]  pc_sel;
  logic        ir_ld, ir_clr, mem_rd, mem_wr;
  logic [1:0]  mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel;
  logic        rf_w_addr_sel, rf_w_wr, rf_r0_addr_sel, rf_r0_rd, rf_r1_rd;
  logic        prev_ld, nzp_ld, nzp_clr;
  logic [1:0]  alu_sel;
  logic        alu_first_val_sel, halted;
`ifdef PUNC_CTRL_PERF_EN
  logic [15:0] retired_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  punc_control dut (
    .clk(clk), .rst(rst), .ir(ir), .nzp_true(nzp_true),
    .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_sel(pc_sel),
    .ir_ld(ir_ld), .ir_clr(ir_clr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_r_addr_sel(mem_r_addr_sel), .mem_w_addr_sel(mem_w_addr_sel),
    .rf_w_data_sel(rf_w_data_sel), .rf_w_addr_sel(rf_w_addr_sel), .rf_w_wr(rf_w_wr),
    .rf_r0_addr_sel(rf_r0_addr_sel), .rf_r0_rd(rf_r0_rd), .rf_r1_rd(rf_r1_rd),
    .prev_ld(prev_ld), .nzp_ld(nzp_ld), .nzp_clr(nzp_clr),
    .alu_sel(alu_sel), .alu_first_val_sel(alu_first_val_sel),
`ifdef PUNC_CTRL_PERF_EN
    .retired_count(retired_count),
`endif
    .halted(halted)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle; inputs change just after the edge, checks run at negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [15:0] instr);
    next_cycle();
    ir = instr;
    @(negedge clk);
    check("fetch_mem_rd", 16'(mem_rd), 16'd1);
    check("fetch_ir_ld",  16'(ir_ld),  16'd1);
    check("fetch_pc_inc", 16'(pc_inc), 16'd1);
    check("fetch_pc_ld",  16'(pc_ld),  16'd0);
    next_cycle();
    @(negedge clk);
    check("decode_quiet", {12'd0, rf_w_wr, mem_wr, pc_ld, ir_ld}, 16'd0);
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; ir = 16'h0000; nzp_true = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_forced_pc_clr", 16'(pc_clr), 16'd1);
    check("rst_forced_ir_ld",  16'(ir_ld),  16'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("init_clears", {13'd0, pc_clr, ir_clr, nzp_clr}, 16'h0007);
    check("init_mem_rd", 16'(mem_rd), 16'd0);

    // ADD R1,R1,#1
    fetch_decode(16'h1261);
    @(negedge clk);
    check("add_imm_alu_sel", 16'(alu_sel), 16'd1);
    check("add_imm_first",   16'(alu_first_val_sel), 16'd0);
    check("add_imm_wr_nzp",  {14'd0, rf_w_wr, nzp_ld}, 16'h0003);
    check("add_imm_r0_rd",   16'(rf_r0_rd), 16'd0);

    // ADD R0,R1,R2 (register mode)
    fetch_decode(16'h1042);
    @(negedge clk);
    check("add_reg_first",   16'(alu_first_val_sel), 16'd1);
    check("add_reg_r0_sel",  {14'd0, rf_r0_addr_sel, rf_r0_rd}, 16'h0003);
    check("add_reg_waddr",   16'(rf_w_addr_sel), 16'd1);

    // BRnp, not taken then taken
    fetch_decode(16'h0A05);
    nzp_true = 1'b0;
    @(negedge clk);
    check("br_nt_pc_ld", 16'(pc_ld), 16'd0);
    fetch_decode(16'h0A05);
    nzp_true = 1'b1;
    @(negedge clk);
    check("br_t_pc_ld",  16'(pc_ld),  16'd1);
    check("br_t_pc_sel", 16'(pc_sel), 16'd0);
    check("br_t_pc_inc", 16'(pc_inc), 16'd0);
    nzp_true = 1'b0;

    // JSR #offset11
    fetch_decode(16'h4802);
    @(negedge clk);
    check("jsr_pc_sel",  16'(pc_sel), 16'd1);
    check("jsr_wdata",   16'(rf_w_data_sel), 16'd3);
    check("jsr_waddr_r7", 16'(rf_w_addr_sel), 16'd0);
    check("jsr_ld_wr",   {14'd0, pc_ld, rf_w_wr}, 16'h0003);

    // LDR R0,R1,#2
    fetch_decode(16'h6042);
    @(negedge clk);
    check("ldr_raddr", 16'(mem_r_addr_sel), 16'd3);
    check("ldr_r1_rd", 16'(rf_r1_rd), 16'd1);
    check("ldr_wdata", 16'(rf_w_data_sel), 16'd2);

    // STI R0,#3 : four-cycle instruction
    fetch_decode(16'hB003);
    @(negedge clk);
    check("sti_exec_prev_ld", 16'(prev_ld), 16'd1);
    check("sti_exec_raddr",   16'(mem_r_addr_sel), 16'd1);
    check("sti_exec_mem_wr",  16'(mem_wr), 16'd0);
    next_cycle();
    @(negedge clk);
    check("sti_exec2_mem_wr", 16'(mem_wr), 16'd1);
    check("sti_exec2_waddr",  16'(mem_w_addr_sel), 16'd1);
    check("sti_exec2_r0_rd",  16'(rf_r0_rd), 16'd1);
    check("sti_exec2_ir_ld",  16'(ir_ld), 16'd0);

    // LDI R1,#3
    fetch_decode(16'hA203);
    @(negedge clk);
    check("ldi_exec_wr_nzp", {14'd0, rf_w_wr, nzp_ld}, 16'h0002);
    next_cycle();
    @(negedge clk);
    check("ldi_exec2_raddr",  16'(mem_r_addr_sel), 16'd2);
    check("ldi_exec2_wr_nzp", {14'd0, rf_w_wr, nzp_ld}, 16'h0003);

    // ST R0,#3 completes normally
    fetch_decode(16'h3003);
    @(negedge clk);
    check("st_mem_wr", 16'(mem_wr), 16'd1);
    check("st_waddr",  16'(mem_w_addr_sel), 16'd0);

    // ST aborted by reset during EXEC
    fetch_decode(16'h3003);
    rst = 1'b1;
    @(negedge clk);
    check("st_rst_mem_wr", 16'(mem_wr), 16'd0);
    check("st_rst_clears", {13'd0, pc_clr, ir_clr, nzp_clr}, 16'h0007);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_init", 16'(pc_clr), 16'd1);
`ifdef PUNC_CTRL_PERF_EN
    check("retired_after_rst", retired_count, 16'd0);
`endif

    for (int i = 0; i < 3; i++) begin
      fetch_decode(16'h1261);
      @(negedge clk);
      check("add_loop_wr", 16'(rf_w_wr), 16'd1);
    end
    next_cycle();
    @(negedge clk);
    check("fetch_after_adds", 16'(ir_ld), 16'd1);
`ifdef PUNC_CTRL_PERF_EN
    check("retired_three_adds", retired_count, 16'd3);
`endif

    // HALT: previous next_cycle already entered FETCH, so finish fetch/decode manually
    ir = 16'hF025;
    next_cycle();
    @(negedge clk);
    check("halt_decode_quiet", 16'(rf_w_wr), 16'd0);
    next_cycle();
    @(negedge clk);
    check("halted_enter", 16'(halted), 16'd1);
    check("halted_pc_ld", {14'd0, pc_ld, pc_inc}, 16'd0);
    repeat (11) next_cycle();
    @(negedge clk);
    check("halted_held", 16'(halted), 16'd1);
    check("halted_no_fetch", 16'(ir_ld), 16'd0);
`ifdef PUNC_CTRL_PERF_EN
    check("retired_no_halt", retired_count, 16'd3);
`endif
    rst = 1'b1;
    @(negedge clk);
    check("halt_rst_forced", 16'(halted), 16'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("halt_rst_init", {13'd0, pc_clr, ir_clr, halted}, 16'h0006);
    next_cycle();
    @(negedge clk);
    check("restart_fetch", 16'(ir_ld), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
